pipeline_ex_unit: RTL

Parametrised execute stage for the pipelined core. It accepts one decoded operation per handshake: PC, rs1, rs2, immediate, B-source select and op code. It computes the ALU result, zero flag, branch target and PC+4 into a registered EX/MEM output slot. Unlike the single-cycle execute stage it replaces, it has a configurable datapath width, valid/ready back-pressure, flush, and an optional iterative multiply/divide unit that stalls the pipe while busy.

---
 rtl/pipeline_ex_unit.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_ex_unit.sv
// pipeline_ex_unit: execute stage with a registered EX/MEM output slot.
// Accepts one decoded operation per valid/ready handshake. It computes the
// ALU result, zero flag, branch target (pc+imm) and pc+4. Results are held
// in an output slot until downstream consumes them.
// Optional iterative MUL/MULHU/DIVU/REMU unit: define EX_MULDIV_EN.
// Without EX_MULDIV_EN, ops 16-19 are reported illegal in one cycle.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     kill held result and any in-flight multi-cycle op
//   in_valid / in_ready       input handshake
//   pc_in, rs1_in, rs2_in,
//   imm_in, alusrc_b_in,
//   op_in                     decoded operation
//   out_valid / out_ready     output slot handshake
//   alu_out, zero_out,
//   pc_tgt_out, pc4_out,
//   rs2_out, illegal_out      output slot fields
module pipeline_ex_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_in,
  input  logic [XLEN-1:0] rs2_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic            alusrc_b_in,
  input  logic [4:0]      op_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_out,
  output logic            zero_out,
  output logic [XLEN-1:0] pc_tgt_out,
  output logic [XLEN-1:0] pc4_out,
  output logic [XLEN-1:0] rs2_out,
  output logic            illegal_out
);

  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLL   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_MUL   = 5'd16;
  localparam logic [4:0] OP_MULHU = 5'd17;
  localparam logic [4:0] OP_DIVU  = 5'd18;
  localparam logic [4:0] OP_REMU  = 5'd19;

  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_c;
  logic [XLEN-1:0] pc_tgt_c;
  logic [XLEN-1:0] pc4_c;
  logic            illegal_c;
  logic            is_md_c;
  logic            slot_free;
  logic            accept;
  logic            load_single;

  // Single-cycle ALU and operation classification.
  always_comb begin
    op_b      = alusrc_b_in ? imm_in : rs2_in;
    alu_c     = '0;
    illegal_c = 1'b0;
    is_md_c   = 1'b0;
    case (op_in)
      OP_ADD:  alu_c = rs1_in + op_b;
      OP_SUB:  alu_c = rs1_in - op_b;
      OP_AND:  alu_c = rs1_in & op_b;
      OP_OR:   alu_c = rs1_in | op_b;
      OP_XOR:  alu_c = rs1_in ^ op_b;
      OP_SLL:  alu_c = rs1_in << op_b[SHW-1:0];
      OP_SRL:  alu_c = rs1_in >> op_b[SHW-1:0];
      OP_SRA:  alu_c = XLEN'($signed(rs1_in) >>> op_b[SHW-1:0]);
      OP_SLT:  alu_c = XLEN'($signed(rs1_in) < $signed(op_b));
      OP_SLTU: alu_c = XLEN'(rs1_in < op_b);
      OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: begin
`ifdef EX_MULDIV_EN
        is_md_c   = 1'b1;
`else
        illegal_c = 1'b1;
`endif
      end
      default: illegal_c = 1'b1;
    endcase
  end

  assign pc_tgt_c  = pc_in + imm_in;
  assign pc4_c     = pc_in + XLEN'(4);
  assign slot_free = !out_valid || out_ready;

`ifdef EX_MULDIV_EN
  localparam int unsigned CW = $clog2(XLEN + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] md_a_q;    // multiplicand or divisor
  logic [XLEN-1:0] md_hi_q;   // product high / partial remainder
  logic [XLEN-1:0] md_lo_q;   // multiplier->product low / dividend->quotient
  logic [1:0]      md_op_q;   // [1]: divide, [0]: take high/remainder half
  logic [XLEN-1:0] pend_pc_tgt_q;
  logic [XLEN-1:0] pend_pc4_q;
  logic [XLEN-1:0] pend_rs2_q;
  logic            md_start;
  logic            md_step;
  logic            md_done;
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN:0]   div_diff;
  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;
  logic [XLEN-1:0] md_res;

  assign in_ready = (state_q == S_IDLE) && slot_free && !flush;
  assign md_start = accept && is_md_c;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; flush aborts a running operation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (md_start) state_d = S_BUSY;
      S_BUSY: if (flush || cnt_q == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: iterate while the counter runs, complete when it hits zero.
  always_comb begin
    md_step = 1'b0;
    md_done = 1'b0;
    if (state_q == S_BUSY && !flush) begin
      if (cnt_q != '0) md_step = 1'b1;
      else             md_done = 1'b1;
    end
  end

  // One radix-2 step: shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, md_hi_q} + (md_lo_q[0] ? {1'b0, md_a_q} : '0);
    div_shift = {md_hi_q, md_lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, md_a_q};
    if (!md_op_q[1]) begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], md_lo_q[XLEN-1:1]};
    end else if (!div_diff[XLEN]) begin
      step_hi = div_diff[XLEN-1:0];
      step_lo = {md_lo_q[XLEN-2:0], 1'b1};
    end else begin
      step_hi = div_shift[XLEN-1:0];
      step_lo = {md_lo_q[XLEN-2:0], 1'b0};
    end
  end

  // Zero divisor naturally yields all-ones quotient and remainder = dividend.
  assign md_res = md_op_q[0] ? md_hi_q : md_lo_q;

  // Multi-cycle operand/accumulator registers and held side fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '0;
      md_a_q        <= '0;
      md_hi_q       <= '0;
      md_lo_q       <= '0;
      md_op_q       <= '0;
      pend_pc_tgt_q <= '0;
      pend_pc4_q    <= '0;
      pend_rs2_q    <= '0;
    end else if (md_start) begin
      cnt_q         <= CW'(XLEN);
      md_a_q        <= op_in[1] ? op_b : rs1_in;
      md_lo_q       <= op_in[1] ? rs1_in : op_b;
      md_hi_q       <= '0;
      md_op_q       <= op_in[1:0];
      pend_pc_tgt_q <= pc_tgt_c;
      pend_pc4_q    <= pc4_c;
      pend_rs2_q    <= rs2_in;
    end else if (md_step) begin
      cnt_q   <= cnt_q - CW'(1);
      md_hi_q <= step_hi;
      md_lo_q <= step_lo;
    end
  end
`else
  assign in_ready = slot_free && !flush;
`endif

  assign accept      = in_valid && in_ready;
  assign load_single = accept && !is_md_c;

  // Output slot: reset > flush > load > consume.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      alu_out     <= '0;
      zero_out    <= 1'b1;
      pc_tgt_out  <= '0;
      pc4_out     <= '0;
      rs2_out     <= '0;
      illegal_out <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_single) begin
      out_valid   <= 1'b1;
      alu_out     <= alu_c;
      zero_out    <= (alu_c == '0);
      pc_tgt_out  <= pc_tgt_c;
      pc4_out     <= pc4_c;
      rs2_out     <= rs2_in;
      illegal_out <= illegal_c;
`ifdef EX_MULDIV_EN
    end else if (md_done) begin
      out_valid   <= 1'b1;
      alu_out     <= md_res;
      zero_out    <= (md_res == '0);
      pc_tgt_out  <= pend_pc_tgt_q;
      pc4_out     <= pend_pc4_q;
      rs2_out     <= pend_rs2_q;
      illegal_out <= 1'b0;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
